// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy fleet sequencer.
//   fleet_state_e : one-hot fleet state encoding (6 states)
//   SCREEN_*/SHIP_* : playfield geometry shared with the enemy instances
//   min_u10       : unsigned minimum, used for clamped horizontal steps
package enemy_pkg;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_MARCH_R = 6'b000010,
    ST_MARCH_L = 6'b000100,
    ST_DROP    = 6'b001000,
    ST_LANDED  = 6'b010000,
    ST_CLEARED = 6'b100000
  } fleet_state_e;

  localparam int unsigned SCREEN_RIGHT = 629;
  localparam int unsigned SHIP_W       = 40;
  localparam int unsigned SHIP_H       = 10;

  function automatic logic [9:0] min_u10(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/enemy_fleet_ctrl_frame_divider.sv
// Frame divider: 8-bit counter advancing on each enabled frame pulse.
//   clk_i, reset_i : clock, async active-high reset
//   clear_i        : synchronous clear (dominates everything)
//   en_i           : frame pulse qualified by the caller
//   period_i       : frames per terminal pulse; may change every cycle
//   tick_o         : combinational pulse on the frame that reaches the period
module frame_divider (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] period_i,
  output logic       tick_o
);

  logic [7:0] cnt_q, cnt_d;

  // Widened compare so cnt+1 cannot wrap; >= lets a shrinking period fire
  // on the very next frame instead of waiting for a wrap-around.
  assign tick_o = en_i && !clear_i && ({1'b0, cnt_q} + 9'd1 >= {1'b0, period_i});

  // NOTE: combinational blocks use blocking '=' and assign a default first,
  // so every path drives cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) cnt_d = '0;
    else if (en_i)         cnt_d = cnt_q + 8'd1;
  end

  // NOTE: state registers use non-blocking '<=' so all flops update together.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/enemy_fleet_ctrl.sv
// Enemy fleet formation sequencer.
//   clk_i, reset_i  : clock, async active-high reset (returns to IDLE)
//   frame_i         : one pulse per processed frame
//   start_i         : player start, sampled in IDLE and LANDED
//   alive_i         : per-ship alive flags
//   offset_x_o/_y_o : shared formation offsets
//   dir_right_o     : marching direction
//   step_o, drop_o  : one-cycle pulses per horizontal step / drop
//   wave_start_o    : one-cycle pulse that revives all enemies
//   landed_o        : fleet reached the landing row (game over)
//   cleared_o       : all ships dead, waiting to respawn
module enemy_fleet_ctrl
  import enemy_pkg::*;
#(
  parameter int num_enemies_p    = 8,
  parameter int min_period_p     = 4,
  parameter int step_px_p        = 10,
  parameter int max_offset_x_p   = 100,
  parameter int drop_px_p        = 10,
  parameter int land_y_p         = 40,
  parameter int respawn_frames_p = 60
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_i,
  input  logic                     start_i,
  input  logic [num_enemies_p-1:0] alive_i,
  output logic [9:0]               offset_x_o,
  output logic [9:0]               offset_y_o,
  output logic                     dir_right_o,
  output logic                     step_o,
  output logic                     drop_o,
  output logic                     wave_start_o,
  output logic                     landed_o,
  output logic                     cleared_o
);

  localparam logic [9:0] MAX_X      = 10'(max_offset_x_p);
  localparam logic [9:0] STEP_PX    = 10'(step_px_p);
  localparam logic [9:0] DROP_PX    = 10'(drop_px_p);
  localparam logic [9:0] LAND_Y     = 10'(land_y_p);
  localparam logic [7:0] MIN_PERIOD = 8'(min_period_p);
  localparam logic [7:0] RESPAWN    = 8'(respawn_frames_p);

  fleet_state_e state_q, state_d;
  logic [9:0]   offset_x_q, offset_x_d, offset_y_q, offset_y_d;
  logic         dir_right_q, dir_right_d;
  logic         step_q, step_d, drop_q, drop_d, wave_q, wave_d;

  logic [7:0] alive_cnt;
  logic [7:0] period;
  logic       marching, march_tick, respawn_tick;

  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < num_enemies_p; i++) alive_cnt = alive_cnt + 8'(alive_i[i]);
  end

  // Fewer ships -> shorter period -> faster march.
  assign period   = MIN_PERIOD + alive_cnt;
  assign marching = (state_q == ST_MARCH_R) || (state_q == ST_MARCH_L);

  frame_divider u_march_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (!marching),
    .en_i    (frame_i && marching),
    .period_i(period),
    .tick_o  (march_tick)
  );

  frame_divider u_respawn_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (state_q != ST_CLEARED),
    .en_i    (frame_i && (state_q == ST_CLEARED)),
    .period_i(RESPAWN),
    .tick_o  (respawn_tick)
  );

  always_comb begin
    state_d     = state_q;
    offset_x_d  = offset_x_q;
    offset_y_d  = offset_y_q;
    dir_right_d = dir_right_q;
    step_d      = 1'b0;
    drop_d      = 1'b0;
    wave_d      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_LANDED: begin
        if (start_i) begin
          state_d     = ST_MARCH_R;
          offset_x_d  = '0;
          offset_y_d  = '0;
          dir_right_d = 1'b1;
          wave_d      = 1'b1;
        end
      end
      ST_MARCH_R: begin
        // Last kill beats any step in the same cycle.
        if (alive_cnt == '0) state_d = ST_CLEARED;
        else if (march_tick) begin
          step_d = 1'b1;
          if (offset_x_q == MAX_X) state_d = ST_DROP;
          else offset_x_d = offset_x_q + min_u10(STEP_PX, MAX_X - offset_x_q);
        end
      end
      ST_MARCH_L: begin
        if (alive_cnt == '0) state_d = ST_CLEARED;
        else if (march_tick) begin
          step_d = 1'b1;
          if (offset_x_q == '0) state_d = ST_DROP;
          else offset_x_d = offset_x_q - min_u10(STEP_PX, offset_x_q);
        end
      end
      ST_DROP: begin
        if (alive_cnt == '0) state_d = ST_CLEARED;
        else begin
          offset_y_d  = offset_y_q + DROP_PX;
          drop_d      = 1'b1;
          dir_right_d = !dir_right_q;
          if (offset_y_d >= LAND_Y) state_d = ST_LANDED;
          else state_d = dir_right_d ? ST_MARCH_R : ST_MARCH_L;
        end
      end
      ST_CLEARED: begin
        if (respawn_tick) begin
          state_d     = ST_MARCH_R;
          offset_x_d  = '0;
          offset_y_d  = '0;
          dir_right_d = 1'b1;
          wave_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      offset_x_q  <= '0;
      offset_y_q  <= '0;
      dir_right_q <= 1'b1;
      step_q      <= 1'b0;
      drop_q      <= 1'b0;
      wave_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_x_q  <= offset_x_d;
      offset_y_q  <= offset_y_d;
      dir_right_q <= dir_right_d;
      step_q      <= step_d;
      drop_q      <= drop_d;
      wave_q      <= wave_d;
    end
  end

  assign offset_x_o   = offset_x_q;
  assign offset_y_o   = offset_y_q;
  assign dir_right_o  = dir_right_q;
  assign step_o       = step_q;
  assign drop_o       = drop_q;
  assign wave_start_o = wave_q;
  assign landed_o     = (state_q == ST_LANDED);
  assign cleared_o    = (state_q == ST_CLEARED);

endmodule
